// File: rtl/equality_pkg.sv
// Shared definitions for the equality-compare stimulus source: FSM encoding
// and the Galois LFSR tap masks for the two supported operand widths.
package equality_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_galois_step.sv
// One step of a right-shift Galois LFSR; purely combinational.
module lfsr_galois_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] next_out
);

  assign next_out = (state_in >> 1) ^ (state_in[0] ? TAPS : '0);

endmodule

// File: rtl/equality_operand_source.sv
// Generates bursts of operand pairs plus their expected equality results for a
// downstream comparator, paced by a valid/ready handshake.
module equality_operand_source
  import equality_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               COUNT_W  = 16,
  parameter logic [WIDTH-1:0] SEED_A   = 'hA5,
  parameter logic [WIDTH-1:0] SEED_B   = 'h3C,
  parameter int               EQ_EVERY = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic [COUNT_W-1:0] num_pairs_in,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               exp_eq_out,
  output logic               exp_neq_out,
  output logic [WIDTH-1:0]   exp_sel_out,
  output logic               busy_out,
  output logic               done_out,
  output state_e             state_out
);

  localparam logic [WIDTH-1:0] TAPS =
    (WIDTH == 16) ? WIDTH'(LFSR_TAPS_16) : WIDTH'(LFSR_TAPS_8);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0]   lfsr_a_nxt, lfsr_b_nxt;
  logic [COUNT_W-1:0] count_q, count_d, num_q, num_d;
  logic               force_eq;
  logic               xfer;
  logic [WIDTH-1:0]   b_raw;

  lfsr_galois_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_a (
    .state_in (lfsr_a_q),
    .next_out (lfsr_a_nxt)
  );

  lfsr_galois_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_b (
    .state_in (lfsr_b_q),
    .next_out (lfsr_b_nxt)
  );

  // Handshake: a pair transfers on any rising edge where valid_out && ready_in;
  // while valid_out is high and ready_in is low, every data output holds.
  assign xfer = (state_q == ST_RUN) && ready_in;

  generate
    if (EQ_EVERY != 0) begin : g_force
      assign force_eq = ((count_q % COUNT_W'(EQ_EVERY)) == COUNT_W'(EQ_EVERY - 1));
    end else begin : g_no_force
      assign force_eq = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= ST_IDLE;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      count_q  <= '0;
      num_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      count_q  <= count_d;
      num_q    <= num_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    count_d  = count_q;
    num_d    = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (num_pairs_in != '0) begin
            state_d  = ST_RUN;
            lfsr_a_d = SEED_A;
            lfsr_b_d = SEED_B;
            num_d    = num_pairs_in;
            count_d  = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          lfsr_a_d = lfsr_a_nxt;
          lfsr_b_d = lfsr_b_nxt;
          if (count_q == num_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Expected results come from the driven operands, so natural collisions count.
  always_comb begin
    valid_out   = 1'b0;
    busy_out    = 1'b0;
    done_out    = 1'b0;
    a_out       = '0;
    b_out       = '0;
    b_raw       = force_eq ? lfsr_a_q : lfsr_b_q;
    exp_eq_out  = 1'b0;
    exp_neq_out = 1'b0;
    exp_sel_out = '0;
    if (state_q == ST_RUN) begin
      valid_out   = 1'b1;
      busy_out    = 1'b1;
      a_out       = lfsr_a_q;
      b_out       = b_raw;
      exp_eq_out  = (lfsr_a_q == b_raw);
      exp_neq_out = (lfsr_a_q != b_raw);
      exp_sel_out = (lfsr_a_q == b_raw) ? lfsr_a_q : b_raw;
    end
    if (state_q == ST_DONE) begin
      done_out = 1'b1;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_equality_operand_source.sv
// Directed bench for equality_operand_source with default parameters.
module tb_equality_operand_source;
  import equality_pkg::*;

  localparam int PW = 26;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [15:0] num_pairs_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic        exp_eq_out;
  logic        exp_neq_out;
  logic [7:0]  exp_sel_out;
  logic        busy_out;
  logic        done_out;
  state_e      state_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs;

  equality_operand_source dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .num_pairs_in (num_pairs_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .a_out        (a_out),
    .b_out        (b_out),
    .exp_eq_out   (exp_eq_out),
    .exp_neq_out  (exp_neq_out),
    .exp_sel_out  (exp_sel_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .state_out    (state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  assign obs = {a_out, b_out, exp_eq_out, exp_neq_out, exp_sel_out};

  function automatic logic [PW-1:0] pw(logic [7:0] a, logic [7:0] b, logic eq, logic [7:0] sel);
    return {a, b, eq, ~eq, sel};
  endfunction

  task automatic test_reset();
    reset_in = 1'b1; start_in = 1'b0; num_pairs_in = '0; ready_in = 1'b0;
    #1;
    n_cmp++;
    if ({valid_out, busy_out, done_out, obs} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v%b b%b d%b %h exp all 0", valid_out, busy_out, done_out, obs);
    end
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (state_out !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state got %0d exp %0d", state_out, ST_IDLE);
    end
    reset_in = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd3; ready_in = 1'b1;
    exp_q = {pw(8'hA5, 8'h3C, 1'b0, 8'h3C), pw(8'hEA, 8'h1E, 1'b0, 8'h1E),
             pw(8'h75, 8'h0F, 1'b0, 8'h0F)};
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_in);
      n_cmp++;
      if (valid_out !== 1'b1 || busy_out !== 1'b1 || obs !== exp_q[0]) begin
        n_err++;
        $display("FAIL basic_pair%0d got v%b %h exp v1 %h", i, valid_out, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b1 || valid_out !== 1'b0 || obs !== '0) begin
      n_err++;
      $display("FAIL basic_done got d%b v%b %h exp d1 v0 0", done_out, valid_out, obs);
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b0 || state_out !== ST_IDLE) begin
      n_err++;
      $display("FAIL basic_idle got d%b st%0d exp d0 st0", done_out, state_out);
    end
  endtask

  task automatic test_eq_force();
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd4; ready_in = 1'b1;
    exp_q = {pw(8'hA5, 8'h3C, 1'b0, 8'h3C), pw(8'hEA, 8'h1E, 1'b0, 8'h1E),
             pw(8'h75, 8'h0F, 1'b0, 8'h0F), pw(8'h82, 8'h82, 1'b1, 8'h82)};
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_in);
      n_cmp++;
      if (valid_out !== 1'b1 || obs !== exp_q[0]) begin
        n_err++;
        $display("FAIL eqforce_pair%0d got v%b %h exp v1 %h", i, valid_out, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b1) begin
      n_err++;
      $display("FAIL eqforce_done got %b exp 1", done_out);
    end
  endtask

  task automatic test_stall();
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd4; ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    n_cmp++;
    if (obs !== pw(8'hA5, 8'h3C, 1'b0, 8'h3C)) begin
      n_err++;
      $display("FAIL stall_pair0 got %h exp %h", obs, pw(8'hA5, 8'h3C, 1'b0, 8'h3C));
    end
    @(negedge clk_in);
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (valid_out !== 1'b1 || busy_out !== 1'b1 || obs !== pw(8'hEA, 8'h1E, 1'b0, 8'h1E)) begin
        n_err++;
        $display("FAIL stall_hold%0d got v%b %h exp v1 %h", i, valid_out, obs,
                 pw(8'hEA, 8'h1E, 1'b0, 8'h1E));
      end
    end
    ready_in = 1'b1;
    exp_q = {pw(8'h75, 8'h0F, 1'b0, 8'h0F), pw(8'h82, 8'h82, 1'b1, 8'h82)};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (valid_out !== 1'b1 || obs !== exp_q[0]) begin
        n_err++;
        $display("FAIL stall_resume%0d got v%b %h exp v1 %h", i, valid_out, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done got %b exp 1", done_out);
    end
  endtask

  task automatic test_zero();
    int n_done = 0;
    int n_valid = 0;
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd0; ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_in);
      if (done_out === 1'b1) n_done++;
      if (valid_out !== 1'b0) n_valid++;
    end
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL zero_done_pulses got %0d exp 1", n_done);
    end
    n_cmp++;
    if (n_valid != 0) begin
      n_err++;
      $display("FAIL zero_valid_cycles got %0d exp 0", n_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd10; ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if (obs !== pw(8'h75, 8'h0F, 1'b0, 8'h0F)) begin
      n_err++;
      $display("FAIL rstmid_pair2 got %h exp %h", obs, pw(8'h75, 8'h0F, 1'b0, 8'h0F));
    end
    #1 reset_in = 1'b1;
    #1;
    n_cmp++;
    if ({valid_out, busy_out, done_out, obs} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async got v%b b%b d%b %h exp all 0", valid_out, busy_out, done_out, obs);
    end
    repeat (2) begin
      @(negedge clk_in);
      if (done_out !== 1'b0) n_done++;
    end
    reset_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out !== 1'b0) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done got %0d exp 0", n_done);
    end
    start_in = 1'b1; num_pairs_in = 16'd1;
    @(negedge clk_in);
    start_in = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b1 || obs !== pw(8'hA5, 8'h3C, 1'b0, 8'h3C)) begin
      n_err++;
      $display("FAIL rstmid_replay got v%b %h exp v1 %h", valid_out, obs, pw(8'hA5, 8'h3C, 1'b0, 8'h3C));
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_replay_done got %b exp 1", done_out);
    end
  endtask

  task automatic test_start_in_run();
    @(negedge clk_in);
    start_in = 1'b1; num_pairs_in = 16'd3; ready_in = 1'b1;
    exp_q = {pw(8'hA5, 8'h3C, 1'b0, 8'h3C), pw(8'hEA, 8'h1E, 1'b0, 8'h1E),
             pw(8'h75, 8'h0F, 1'b0, 8'h0F)};
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_in);
      if (i == 1) begin
        start_in = 1'b1; num_pairs_in = 16'd8;
      end else begin
        start_in = 1'b0;
      end
      n_cmp++;
      if (valid_out !== 1'b1 || obs !== exp_q[0]) begin
        n_err++;
        $display("FAIL runstart_pair%0d got v%b %h exp v1 %h", i, valid_out, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b1 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL runstart_done got d%b v%b exp d1 v0", done_out, valid_out);
    end
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eq_force();
    test_stall();
    test_zero();
    test_reset_mid();
    test_start_in_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
